// File: rtl/reset_seq.sv
// Reset sequencer: synchronizes request inputs, holds every channel for a quiet period, then
// releases channels one by one. Optional status register enabled by macro RESET_SEQ_STATUS_EN.
module reset_seq #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PULSE   = 16,
    parameter int unsigned STAGGER     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_async,
    input  logic              sw_req,
    output logic [NUM_CH-1:0] rst_out,
`ifdef RESET_SEQ_STATUS_EN
    input  logic              cause_clr,
    output logic [NUM_CH:0]   cause,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {StHold, StRelease, StIdle} state_e;

    localparam logic [7:0] QUIET_LAST = 8'(MIN_PULSE - 1);
    localparam logic [7:0] STAG_LAST  = (STAGGER == 0) ? 8'd0 : 8'(STAGGER - 1);
    localparam logic [3:0] LAST_IDX   = 4'(NUM_CH - 1);
    // With one channel or no stagger, every channel drops on the HOLD exit edge.
    localparam bit         FAST_REL   = (NUM_CH == 1) || (STAGGER == 0);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
        $error("reset_seq: NUM_CH out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
        $error("reset_seq: SYNC_STAGES out of range");
    end
    if (MIN_PULSE < 1 || MIN_PULSE > 255) begin : g_chk_min_pulse
        $error("reset_seq: MIN_PULSE out of range");
    end
    if (STAGGER > 255) begin : g_chk_stagger
        $error("reset_seq: STAGGER out of range");
    end

    // Request synchronizers; preset to ones so a block reset also looks like a live request.
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] req_sync;
    logic              req_act;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= req_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign req_sync = sync_q[SYNC_STAGES-1];
    assign req_act  = (|req_sync) | sw_req;

    state_e            state_q, state_d;
    logic [7:0]        quiet_q, quiet_d;
    logic [7:0]        stag_q, stag_d;
    logic [3:0]        idx_q, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              busy_q;

    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        stag_d  = stag_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        unique case (state_q)
            StHold: begin
                rst_d = '1;
                if (req_act) begin
                    quiet_d = '0;
                end else if (quiet_q == QUIET_LAST) begin
                    quiet_d = '0;
                    stag_d  = '0;
                    if (FAST_REL) begin
                        rst_d   = '0;
                        state_d = StIdle;
                    end else begin
                        rst_d[0] = 1'b0;
                        idx_d    = 4'd1;
                        state_d  = StRelease;
                    end
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            StRelease: begin
                // A new request beats any release due on this edge.
                if (req_act) begin
                    rst_d   = '1;
                    quiet_d = '0;
                    stag_d  = '0;
                    state_d = StHold;
                end else if (stag_q == STAG_LAST) begin
                    stag_d = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_q == 4'(i)) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    stag_d = stag_q + 8'd1;
                end
            end
            StIdle: begin
                rst_d = '0;
                if (req_act) begin
                    rst_d   = '1;
                    quiet_d = '0;
                    stag_d  = '0;
                    state_d = StHold;
                end
            end
            default: begin
                rst_d   = '1;
                quiet_d = '0;
                stag_d  = '0;
                state_d = StHold;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StHold;
            quiet_q <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= |rst_d;
        end
    end

    assign rst_out = rst_q;
    assign busy    = busy_q;

`ifdef RESET_SEQ_STATUS_EN
    // Sticky cause bits; a set on the same edge as a clear survives.
    logic [NUM_CH:0] cause_q, cause_d;

    always_comb begin
        cause_d = cause_clr ? '0 : cause_q;
        cause_d = cause_d | {sw_req, req_sync};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= '0;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Directed self-checking bench for reset_seq: default instance plus a STAGGER=0 instance
// sharing the same stimulus.
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_req;
    logic [3:0] req_async;
    logic [3:0] rst_out, rst_out_s0;
    logic       busy, busy_s0;
`ifdef RESET_SEQ_STATUS_EN
    logic       cause_clr;
    logic [4:0] cause, cause_s0;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reset_seq #(
        .NUM_CH(4), .SYNC_STAGES(2), .MIN_PULSE(16), .STAGGER(4)
    ) dut (
        .clk(clk), .reset(reset), .req_async(req_async), .sw_req(sw_req),
        .rst_out(rst_out),
`ifdef RESET_SEQ_STATUS_EN
        .cause_clr(cause_clr), .cause(cause),
`endif
        .busy(busy)
    );

    reset_seq #(
        .NUM_CH(4), .SYNC_STAGES(2), .MIN_PULSE(16), .STAGGER(0)
    ) dut_s0 (
        .clk(clk), .reset(reset), .req_async(req_async), .sw_req(sw_req),
        .rst_out(rst_out_s0),
`ifdef RESET_SEQ_STATUS_EN
        .cause_clr(cause_clr), .cause(cause_s0),
`endif
        .busy(busy_s0)
    );

    // Advance one edge; outputs are then stable and inputs may be changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sw_req    = 1'b0;
        req_async = 4'h0;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    // Expected rst_out of the staggered instance at cycle c after reset release.
    function automatic logic [3:0] exp_pwr(input int c);
        if (c < 18) return 4'hF;
        if (c < 22) return 4'hE;
        if (c < 26) return 4'hC;
        if (c < 30) return 4'h8;
        return 4'h0;
    endfunction

    function automatic logic [3:0] exp_pwr_s0(input int c);
        return (c < 18) ? 4'hF : 4'h0;
    endfunction

    task automatic run_powerup(input string tag);
        logic [3:0] e;
        logic [3:0] e0;
        for (int c = 1; c <= 31; c++) begin
            cyc();
            e  = exp_pwr(c);
            e0 = exp_pwr_s0(c);
            total++;
            if (rst_out !== e)
                $display("FAIL %s_rst cycle %0d: got %h expected %h", tag, c, rst_out, e);
            else passed++;
            total++;
            if (busy !== (e != 4'h0))
                $display("FAIL %s_busy cycle %0d: got %b expected %b", tag, c, busy, e != 4'h0);
            else passed++;
            total++;
            if (rst_out_s0 !== e0)
                $display("FAIL %s_s0_rst cycle %0d: got %h expected %h", tag, c, rst_out_s0, e0);
            else passed++;
            total++;
            if (busy_s0 !== (e0 != 4'h0))
                $display("FAIL %s_s0_busy cycle %0d: got %b expected %b", tag, c, busy_s0,
                         e0 != 4'h0);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        sw_req    = 1'b0;
        req_async = 4'h0;
`ifdef RESET_SEQ_STATUS_EN
        cause_clr = 1'b0;
`endif
        repeat (3) cyc();
        total++;
        if (rst_out !== 4'hF || busy !== 1'b1)
            $display("FAIL reset_state: got rst=%h busy=%b expected rst=f busy=1", rst_out, busy);
        else passed++;
        total++;
        if (rst_out_s0 !== 4'hF || busy_s0 !== 1'b1)
            $display("FAIL reset_state_s0: got rst=%h busy=%b expected rst=f busy=1",
                     rst_out_s0, busy_s0);
        else passed++;
`ifdef RESET_SEQ_STATUS_EN
        total++;
        if (cause !== 5'b0)
            $display("FAIL reset_cause: got %b expected 00000", cause);
        else passed++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_powerup();
        run_powerup("powerup");
    endtask

    task automatic test_async_req();
        // Starts in IDLE after test_powerup.
        req_async = 4'b0100;
        cyc();
        req_async = 4'h0;
        cyc();
        total++;
        if (rst_out !== 4'h0)
            $display("FAIL async_edge2: got %h expected 0", rst_out);
        else passed++;
        cyc();
        total++;
        if (rst_out !== 4'hF || busy !== 1'b1)
            $display("FAIL async_edge3: got rst=%h busy=%b expected rst=f busy=1", rst_out, busy);
        else passed++;
        total++;
        if (rst_out_s0 !== 4'hF)
            $display("FAIL async_edge3_s0: got %h expected f", rst_out_s0);
        else passed++;
        repeat (15) cyc();
        total++;
        if (rst_out !== 4'hF)
            $display("FAIL async_hold15: got %h expected f", rst_out);
        else passed++;
        cyc();
        total++;
        if (rst_out !== 4'hE)
            $display("FAIL async_release16: got %h expected e", rst_out);
        else passed++;
        total++;
        if (rst_out_s0 !== 4'h0)
            $display("FAIL async_release16_s0: got %h expected 0", rst_out_s0);
        else passed++;
    endtask

    task automatic test_sw_req();
        do_reset();
        repeat (24) cyc();
        total++;
        if (rst_out !== 4'hC)
            $display("FAIL sw_pre cycle 24: got %h expected c", rst_out);
        else passed++;
        sw_req = 1'b1;
        cyc();
        sw_req = 1'b0;
        total++;
        if (rst_out !== 4'hF || busy !== 1'b1)
            $display("FAIL sw_next cycle 25: got rst=%h busy=%b expected rst=f busy=1",
                     rst_out, busy);
        else passed++;
        total++;
        if (rst_out_s0 !== 4'hF)
            $display("FAIL sw_next_s0 cycle 25: got %h expected f", rst_out_s0);
        else passed++;
        for (int c = 26; c <= 40; c++) begin
            cyc();
            total++;
            if (rst_out !== 4'hF)
                $display("FAIL sw_hold cycle %0d: got %h expected f", c, rst_out);
            else passed++;
        end
        cyc();
        total++;
        if (rst_out !== 4'hE)
            $display("FAIL sw_release cycle 41: got %h expected e", rst_out);
        else passed++;
        total++;
        if (rst_out_s0 !== 4'h0)
            $display("FAIL sw_release_s0 cycle 41: got %h expected 0", rst_out_s0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (19) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++;
        if (rst_out !== 4'hF || busy !== 1'b1)
            $display("FAIL midreset cycle 20: got rst=%h busy=%b expected rst=f busy=1",
                     rst_out, busy);
        else passed++;
        total++;
        if (rst_out_s0 !== 4'hF)
            $display("FAIL midreset_s0 cycle 20: got %h expected f", rst_out_s0);
        else passed++;
        run_powerup("midreset");
    endtask

`ifdef RESET_SEQ_STATUS_EN
    task automatic test_cause();
        do_reset();
        repeat (5) cyc();
        total++;
        if (cause !== 5'b01111)
            $display("FAIL cause_after_reset: got %b expected 01111", cause);
        else passed++;
        cause_clr = 1'b1;
        cyc();
        cause_clr = 1'b0;
        total++;
        if (cause !== 5'b0)
            $display("FAIL cause_clear_initial: got %b expected 00000", cause);
        else passed++;
        req_async = 4'b0010;
        sw_req    = 1'b1;
        cyc();
        sw_req = 1'b0;
        repeat (2) cyc();
        req_async = 4'h0;
        repeat (3) cyc();
        total++;
        if (cause !== 5'b10010)
            $display("FAIL cause_set: got %b expected 10010", cause);
        else passed++;
        cause_clr = 1'b1;
        cyc();
        cause_clr = 1'b0;
        total++;
        if (cause !== 5'b0)
            $display("FAIL cause_clr_idle: got %b expected 00000", cause);
        else passed++;
        cause_clr = 1'b1;
        sw_req    = 1'b1;
        cyc();
        cause_clr = 1'b0;
        sw_req    = 1'b0;
        total++;
        if (cause !== 5'b10000)
            $display("FAIL cause_set_wins: got %b expected 10000", cause);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_powerup();
        test_async_req();
        test_sw_req();
        test_reset_mid();
`ifdef RESET_SEQ_STATUS_EN
        test_cause();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
